// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable sequence detector controller:
// default widths and the controller state encoding.
package seq_det_pkg;

  localparam int unsigned PAT_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Config handshake, serial stream and status bundle for seq_det_ctrl.
//   master : host/bit-source side (drives cfg_*, abort, in, in_valid)
//   slave  : detector side (drives cfg_ready, out, busy, done, match_count)
interface seq_det_ctrl_if #(
  parameter int unsigned PAT_W = seq_det_pkg::PAT_W_DEF,
  parameter int unsigned CNT_W = seq_det_pkg::CNT_W_DEF
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_target;
  logic             abort;
  logic             in;
  logic             in_valid;
  logic             out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_count;

  modport master (
    output cfg_valid, cfg_pattern, cfg_target, abort, in, in_valid,
    input  cfg_ready, out, busy, done, match_count
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_target, abort, in, in_valid,
    output cfg_ready, out, busy, done, match_count
  );

endinterface

// File: rtl/seq_det_window.sv
// Sliding window for the sequence detector: PAT_W-1 bit history shift
// register, a saturating fill counter and the pattern comparator.
//   clk, reset : clock, async active-high reset
//   shift_en   : accept "in" into the window this cycle
//   clr        : clear history and fill (takes priority)
//   restart    : on a shift, restart filling (non-overlapping matches)
//   in         : serial bit
//   pattern    : latched pattern, MSB compared against the oldest bit
//   hit        : window is full and {hist, in} equals pattern (combinational)
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             restart,
  input  logic             in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam int unsigned HIST_W = PAT_W - 1;
  localparam int unsigned FILL_W = $clog2(PAT_W);
  localparam int unsigned FULL   = PAT_W - 1;

  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // Compare against the current bit so the match is reported in its own cycle.
  always_comb begin
    hit = (fill_q == FILL_W'(FULL)) && ({hist_q, in} == pattern);
  end

  // Window update: clear dominates, otherwise shift on qualified bits.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = HIST_W'({hist_q, in});
      if (restart) begin
        fill_d = '0;
      end else if (fill_q != FILL_W'(FULL)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Controller around a programmable serial Mealy sequence detector.
// Takes a pattern and match target over a valid/ready config port, arms,
// scans the qualified serial stream, counts matches (saturating) and stops
// in DONE once the target is reached (target 0 = free-run).
//   clk, reset : clock, async active-high reset
//   bus        : seq_det_ctrl_if.slave (cfg handshake, abort, stream, status)
//                out is the combinational Mealy match; all other status registered.
// Build option: SEQ_DET_OVERLAP_EN keeps the window full after a match so
// overlapping occurrences are counted; default restarts the window.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  seq_det_ctrl_if.slave     bus
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic cfg_hs;
  logic armed;
  logic shift_en;
  logic win_clr;
  logic win_restart;
  logic hit;
  logic match;

  assign cfg_hs   = bus.cfg_valid & cfg_ready_q;
  assign armed    = (state_q == S_ARMED);
  // abort suppresses both the shift and any same-cycle match.
  assign shift_en = armed & bus.in_valid & ~bus.abort;
  assign match    = shift_en & hit;
  assign win_clr  = cfg_hs | (armed & bus.abort);

`ifdef SEQ_DET_OVERLAP_EN
  assign win_restart = 1'b0;
`else
  assign win_restart = match;
`endif

  seq_det_window #(.PAT_W(PAT_W)) u_window (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .clr      (win_clr),
    .restart  (win_restart),
    .in       (bus.in),
    .pattern  (pattern_q),
    .hit      (hit)
  );

  // Next state, config latch and match counter.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    target_d  = target_q;
    count_d   = count_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_hs) begin
          state_d   = S_ARMED;
          pattern_d = bus.cfg_pattern;
          target_d  = bus.cfg_target;
          count_d   = '0;
        end
      end
      S_ARMED: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (match) begin
          if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + CNT_W'(1);
          end
          if ((target_q != '0) && (count_d == target_q)) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Status flops track the next state so they line up with state_q.
    cfg_ready_d = (state_d != S_ARMED);
    busy_d      = (state_d == S_ARMED);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pattern_q   <= '0;
      target_q    <= '0;
      count_q     <= '0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      target_q    <= target_d;
      count_q     <= count_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.cfg_ready   = cfg_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.match_count = count_q;
  assign bus.out         = match;

endmodule
